// File: rtl/bin_to_bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// BIN_TO_BCD_BLANK_EN enables leading-zero blanking on the bcd output.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // ceil(width * log10(2)), in fixed point to stay integer-only
  function automatic int digits_needed(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
// Included by bin_to_bcd_seq, which reads BIN_TO_BCD_BLANK_EN.
module bcd_add3 (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Define BIN_TO_BCD_BLANK_EN to blank leading zero digits with 4'hF.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = 4 * DIGITS + WIDTH;

  generate
    if (DIGITS < digits_needed(WIDTH)) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  state_t              r_state;
  state_t              w_nstate;
  logic [WIDTH-1:0]    r_bin;
  logic [4*DIGITS-1:0] r_scr;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_bcd;

  logic [4*DIGITS-1:0] w_adj;
  logic [SW-1:0]       w_shift;
  logic [4*DIGITS-1:0] w_nscr;
  logic [WIDTH-1:0]    w_nbin;
  logic [4*DIGITS-1:0] w_load;
  logic                w_last;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      bcd_add3 u_add3 (
        .i_d (r_scr[4*gi +: 4]),
        .o_d (w_adj[4*gi +: 4])
      );
    end
  endgenerate

  assign w_shift = {w_adj, r_bin} << 1;
  assign w_nscr  = w_shift[SW-1 -: 4*DIGITS];
  assign w_nbin  = w_shift[WIDTH-1:0];
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

`ifdef BIN_TO_BCD_BLANK_EN
  logic w_lead;
  always_comb begin
    w_load = w_nscr;
    w_lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (w_lead && (w_nscr[4*i +: 4] == 4'd0))
        w_load[4*i +: 4] = BCD_BLANK;
      else
        w_lead = 1'b0;
    end
  end
`else
  assign w_load = w_nscr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_nstate = S_SHIFT;
      S_SHIFT: if (w_last)    w_nstate = S_DONE;
      S_DONE:  if (out_ready) w_nstate = S_IDLE;
      default:                w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_scr <= '0;
      r_cnt <= '0;
      r_bcd <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_bin <= bin;
      r_scr <= '0;
      r_cnt <= '0;
    end else if (r_state == S_SHIFT) begin
      r_bin <= w_nbin;
      r_scr <= w_nscr;
      r_cnt <= r_cnt + CW'(1);
      // result register only changes on DONE entry
      if (w_last) r_bcd <= w_load;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign bcd       = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq with a decimal reference model.
// Honors BIN_TO_BCD_BLANK_EN for the expected blanking.
module tb_bin_to_bcd_seq;

  localparam int W = 16;
  localparam int D = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] bin = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [4*D-1:0] bcd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [4*D-1:0] q_exp[$];
  int             q_acc[$];

  bit rand_or = 1'b0;
  bit force_or = 1'b0;
  bit prev_ov = 1'b0;
  bit prev_or = 1'b0;
  logic [4*D-1:0] held;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
    else         out_ready = force_or;
  end

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned p;
    bit lead;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
`ifdef BIN_TO_BCD_BLANK_EN
    lead = 1'b1;
    for (int i = D - 1; i > 0; i--) begin
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    return r;
  endfunction

  // called at #1 after a posedge; returns after the accepting edge
  task automatic send(input int unsigned v, output int acc);
    bit rdy;
    bit ok;
    ok = 1'b0;
    acc = -1;
    in_valid = 1'b1;
    bin = W'(v);
    for (int k = 0; k < 300; k++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        acc = cyc;
        q_exp.push_back(ref_bcd(v));
        q_acc.push_back(cyc);
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) chk(1'b0, "accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #2;
      if (q_exp.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk(1'b0, "drain_timeout", 32'(q_exp.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (q_exp.size() == 0) begin
          chk(1'b0, "spurious_out_valid", 32'(bcd), 0);
        end else begin
          logic [4*D-1:0] e;
          int a;
          e = q_exp.pop_front();
          a = q_acc.pop_front();
          chk(bcd == e, "bcd", 32'(bcd), 32'(e));
          chk(cyc - a == W, "latency", 32'(cyc - a), W);
        end
        held = bcd;
      end else if (out_valid && prev_ov) begin
        chk(bcd == held, "bcd_hold", 32'(bcd), 32'(held));
      end
      if (prev_ov && prev_or)
        chk(!out_valid, "out_valid_drop", 32'(out_valid), 0);
      if (out_valid)
        chk(!in_ready, "in_ready_in_done", 32'(in_ready), 0);
      prev_ov = out_valid;
      prev_or = out_ready;
    end
  end

  initial begin
    int a1, a2, rel;
    int unsigned v;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    chk(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 1);
    chk(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 0);
    chk(bcd == '0, "rst_bcd", 32'(bcd), 0);
    rst_n = 1'b1;
    rel = cyc;

    // first accept right after release, value zero
    force_or = 1'b1;
    send(0, a1);
    chk(a1 == rel + 1, "first_accept", 32'(a1), 32'(rel + 1));
    drain();

    send(65535, a1);
    drain();

    // busy input: 42 presented during the 500 conversion
    send(500, a1);
    in_valid = 1'b1;
    bin = W'(42);
    chk(in_ready == 1'b0, "busy_in_ready", 32'(in_ready), 0);
    send(42, a2);
    chk(a2 - a1 == W + 2, "busy_accept_gap", 32'(a2 - a1), W + 2);
    drain();

    // backpressure
    force_or = 1'b0;
    send(999, a1);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #2;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk(seen, "bp_out_valid", 32'(seen), 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #2;
      chk(bcd == ref_bcd(999), "bp_bcd", 32'(bcd), 32'(ref_bcd(999)));
      chk(out_valid && !in_ready, "bp_flags",
          {30'd0, out_valid, in_ready}, 32'h2);
    end
    force_or = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk(!out_valid && in_ready, "bp_release",
        {30'd0, out_valid, in_ready}, 32'h1);
    drain();

    // reset at shift cycle 8
    send(12345, a1);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk(in_ready == 1'b1, "mid_rst_in_ready", 32'(in_ready), 1);
    chk(out_valid == 1'b0, "mid_rst_out_valid", 32'(out_valid), 0);
    chk(bcd == '0, "mid_rst_bcd", 32'(bcd), 0);
    q_exp.delete();
    q_acc.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (out_valid) seen = 1'b1;
    end
    chk(!seen, "no_result_after_reset", 32'(seen), 0);

    // randomized traffic with random backpressure
    rand_or = 1'b1;
    for (int n = 0; n < 40; n++) begin
      v = $urandom_range(0, 65535);
      if (n == 0) v = 1234;
      if (n == 1) v = 7;
      send(v, a1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    chk(q_exp.size() == 0, "queue_empty", 32'(q_exp.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
